// File: rtl/radar_pkg.sv
// Shared types and helpers for the radar sweep scheduler.
// Holds the FSM state type, default widths and a saturating increment.
package radar_pkg;

  localparam int unsigned DefDataWidth = 32;
  localparam int unsigned DefAzWidth   = 16;
  localparam int unsigned SatWidth     = 64;

  typedef enum logic [1:0] {StIdle, StSync, StRun, StDrain} state_e;

  // Callers zero-extend into SatWidth and truncate the result back to their width.
  function automatic logic [SatWidth-1:0] sat_inc(input logic [SatWidth-1:0] val,
                                                  input logic [SatWidth-1:0] max_val);
    return (val >= max_val) ? max_val : val + {{(SatWidth-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Two-flop synchronizer followed by a rising-edge detector.
// The output is a single-cycle pulse, two clocks after the input rises.
module edge_detect (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic pulse_o
);

  logic [2:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], sig_i};
    end
  end

  assign pulse_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/radar_sweep_scheduler.sv
// Tracks antenna azimuth from ARP/ACP and issues one tagged sweep request per TRIG
// over a REQ/ACK handshake, counting dropped triggers and bad revolutions.
module radar_sweep_scheduler
  import radar_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned AZ_WIDTH   = DefAzWidth
) (
  input  logic                  S_AXIS_ACLK,
  input  logic                  S_AXIS_ARESETN,
  input  logic                  ENABLE,
  input  logic                  CLR_STATS,
  input  logic                  ARP,
  input  logic                  ACP,
  input  logic                  TRIG,
  input  logic                  CALIBRATED,
  input  logic [DATA_WIDTH-1:0] ACP_CNT,
  output logic                  SWEEP_REQ,
  output logic [AZ_WIDTH-1:0]   SWEEP_AZ,
  output logic [DATA_WIDTH-1:0] SWEEP_IDX,
  input  logic                  SWEEP_ACK,
  output logic                  RUNNING,
  output logic [DATA_WIDTH-1:0] MISSED_CNT,
  output logic [DATA_WIDTH-1:0] ARP_ERR_CNT
);

  logic arp_p, acp_p, trig_p;

  edge_detect u_arp_edge (
    .clk_i  (S_AXIS_ACLK),
    .rst_ni (S_AXIS_ARESETN),
    .sig_i  (ARP),
    .pulse_o(arp_p)
  );

  edge_detect u_acp_edge (
    .clk_i  (S_AXIS_ACLK),
    .rst_ni (S_AXIS_ARESETN),
    .sig_i  (ACP),
    .pulse_o(acp_p)
  );

  edge_detect u_trig_edge (
    .clk_i  (S_AXIS_ACLK),
    .rst_ni (S_AXIS_ARESETN),
    .sig_i  (TRIG),
    .pulse_o(trig_p)
  );

  state_e                state_q;
  logic [AZ_WIDTH-1:0]   az_q;
  logic [DATA_WIDTH-1:0] idx_q;

  logic                  active, xfer, arp_mismatch;
  logic [AZ_WIDTH-1:0]   az_start, az_inc, az_next;
  logic [DATA_WIDTH-1:0] idx_base, idx_inc, missed_inc, arp_err_inc;
  logic                  unused_acp_hi;

  assign active       = ENABLE && CALIBRATED;
  assign xfer         = SWEEP_REQ && SWEEP_ACK;
  assign arp_mismatch = az_q != ACP_CNT[AZ_WIDTH-1:0];
  // Only the low AZ_WIDTH bits of the calibrated count matter for comparison.
  assign unused_acp_hi = ^ACP_CNT[DATA_WIDTH-1:AZ_WIDTH];

  assign az_start    = acp_p ? AZ_WIDTH'(1) : '0;
  assign az_inc      = AZ_WIDTH'(sat_inc(SatWidth'(az_q), SatWidth'({AZ_WIDTH{1'b1}})));
  assign az_next     = arp_p ? az_start : (acp_p ? az_inc : az_q);
  assign idx_base    = arp_p ? '0 : idx_q;
  assign idx_inc     = DATA_WIDTH'(sat_inc(SatWidth'(idx_base), SatWidth'({DATA_WIDTH{1'b1}})));
  assign missed_inc  = DATA_WIDTH'(sat_inc(SatWidth'(MISSED_CNT), SatWidth'({DATA_WIDTH{1'b1}})));
  assign arp_err_inc = DATA_WIDTH'(sat_inc(SatWidth'(ARP_ERR_CNT), SatWidth'({DATA_WIDTH{1'b1}})));

  assign RUNNING = (state_q == StRun);

  always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
    if (!S_AXIS_ARESETN) begin
      state_q     <= StIdle;
      az_q        <= '0;
      idx_q       <= '0;
      SWEEP_REQ   <= 1'b0;
      SWEEP_AZ    <= '0;
      SWEEP_IDX   <= '0;
      MISSED_CNT  <= '0;
      ARP_ERR_CNT <= '0;
    end else begin
      if (xfer) begin
        SWEEP_REQ <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (active) state_q <= StSync;
        end
        StSync: begin
          if (!active) begin
            state_q <= StIdle;
          end else if (arp_p) begin
            state_q <= StRun;
            az_q    <= az_start;
            idx_q   <= '0;
          end
        end
        StRun: begin
          if (!active) begin
            // A pending request is never withdrawn; wait for its ACK in DRAIN.
            state_q <= (SWEEP_REQ && !SWEEP_ACK) ? StDrain : StIdle;
          end else begin
            az_q  <= az_next;
            idx_q <= trig_p ? idx_inc : idx_base;
            if (arp_p && arp_mismatch) ARP_ERR_CNT <= arp_err_inc;
            if (trig_p) begin
              if (!SWEEP_REQ || xfer) begin
                SWEEP_REQ <= 1'b1;
                SWEEP_AZ  <= az_next;
                SWEEP_IDX <= idx_base;
              end else begin
                MISSED_CNT <= missed_inc;
              end
            end
          end
        end
        StDrain: begin
          if (xfer) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      if (CLR_STATS) begin
        MISSED_CNT  <= '0;
        ARP_ERR_CNT <= '0;
      end
    end
  end

endmodule

// File: tb/tb_radar_sweep_scheduler.sv
// Scoreboard bench for radar_sweep_scheduler: a revolution-level model predicts each
// sweep request; a monitor pops and compares on every REQ/ACK transfer.
module tb_radar_sweep_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, enable, clr, arp, acp, trig, calibrated, sweep_ack;
  logic [31:0] acp_cnt;
  logic        sweep_req, running;
  logic [15:0] sweep_az;
  logic [31:0] sweep_idx, missed_cnt, arp_err_cnt;

  always #5 clk = ~clk;

  radar_sweep_scheduler dut (
    .S_AXIS_ACLK   (clk),
    .S_AXIS_ARESETN(rst_n),
    .ENABLE        (enable),
    .CLR_STATS     (clr),
    .ARP           (arp),
    .ACP           (acp),
    .TRIG          (trig),
    .CALIBRATED    (calibrated),
    .ACP_CNT       (acp_cnt),
    .SWEEP_REQ     (sweep_req),
    .SWEEP_AZ      (sweep_az),
    .SWEEP_IDX     (sweep_idx),
    .SWEEP_ACK     (sweep_ack),
    .RUNNING       (running),
    .MISSED_CNT    (missed_cnt),
    .ARP_ERR_CNT   (arp_err_cnt)
  );

  typedef struct {
    int unsigned az;
    int unsigned idx;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          lat = 3;
  // Model: mode 0 = not running, 1 = waiting for north, 2 = running.
  int unsigned m_mode, m_az, m_idx, m_missed, m_err, m_pending, acp_cnt_v;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic model_event(input bit a, input bit c, input bit t, input bit force_accept);
    if (m_mode == 1 && a) begin
      m_mode = 2;
      m_az   = c ? 1 : 0;
      m_idx  = 0;
      return;
    end
    if (m_mode != 2) return;
    if (a) begin
      if (m_az != (acp_cnt_v & 32'hFFFF)) m_err++;
      m_az  = c ? 1 : 0;
      m_idx = 0;
    end else if (c && m_az < 65535) begin
      m_az++;
    end
    if (t) begin
      if (m_pending == 0 || force_accept) begin
        exp_q.push_back('{m_az, m_idx});
        if (!sweep_ack) m_pending = 1;
      end else begin
        m_missed++;
      end
      m_idx++;
    end
  endtask

  task automatic pulse(input bit a, input bit c, input bit t);
    model_event(a, c, t, 1'b0);
    arp  = a;
    acp  = c;
    trig = t;
    step(2);
    arp  = 1'b0;
    acp  = 1'b0;
    trig = 1'b0;
    step(2);
  endtask

  task automatic set_ack(input bit v);
    sweep_ack = v;
    if (v) m_pending = 0;
  endtask

  // Learns the TRIG-to-REQ latency so later stimulus can land on the trigger pulse cycle.
  task automatic measure_trig();
    model_event(1'b0, 1'b0, 1'b1, 1'b0);
    trig = 1'b1;
    lat  = 0;
    while (lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (sweep_req) break;
    end
    chk("req_after_trig", 64'(sweep_req), 64'd1);
    @(posedge clk);
    #2;
    trig = 1'b0;
    step(2);
  endtask

  // which = 0: ACK coincides with the trigger pulse; which = 1: CLR_STATS coincides.
  task automatic trig_coincident(input bit which);
    model_event(1'b0, 1'b0, 1'b1, !which);
    if (which) begin
      m_missed = 0;
      m_err    = 0;
    end
    trig = 1'b1;
    step(lat - 1);
    if (which) clr = 1'b1;
    else sweep_ack = 1'b1;
    step(1);
    clr       = 1'b0;
    sweep_ack = 1'b0;
    step(1);
    trig = 1'b0;
    step(2);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req"}, 64'(sweep_req), 64'd0);
    chk({tag, "_az"}, 64'(sweep_az), 64'd0);
    chk({tag, "_idx"}, 64'(sweep_idx), 64'd0);
    chk({tag, "_running"}, 64'(running), 64'd0);
    chk({tag, "_missed"}, 64'(missed_cnt), 64'd0);
    chk({tag, "_arp_err"}, 64'(arp_err_cnt), 64'd0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && sweep_req && sweep_ack) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req actual az=%0d idx=%0d expected no request",
                   sweep_az, sweep_idx);
        end else begin
          e = exp_q.pop_front();
          chk("sweep_az", 64'(sweep_az), 64'(e.az));
          chk("sweep_idx", 64'(sweep_idx), 64'(e.idx));
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin : stim
    bit a, c, t;
    rst_n = 1'b0; enable = 1'b0; clr = 1'b0; arp = 1'b0; acp = 1'b0; trig = 1'b0;
    calibrated = 1'b0; sweep_ack = 1'b0;
    acp_cnt_v = 8; acp_cnt = 32'(acp_cnt_v);
    m_mode = 0; m_az = 0; m_idx = 0; m_missed = 0; m_err = 0; m_pending = 0;
    step(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    step(2);

    enable = 1'b1; calibrated = 1'b1;
    step(3);
    m_mode = 1;
    chk("sync_not_running", 64'(running), 64'd0);
    pulse(1, 0, 0);
    chk("run_after_arp", 64'(running), 64'd1);
    set_ack(1);
    repeat (4) pulse(0, 1, 0);
    measure_trig();
    pulse(0, 0, 1);

    // ACK held low: the first trigger stays pending, the rest are dropped.
    set_ack(0);
    repeat (3) pulse(0, 0, 1);
    chk("missed_after_3", 64'(missed_cnt), 64'(m_missed));
    chk("req_held", 64'(sweep_req), 64'd1);
    set_ack(1);
    @(negedge clk);
    chk("req_in_xfer", 64'(sweep_req), 64'd1);
    @(negedge clk);
    chk("req_drops", 64'(sweep_req), 64'd0);
    step(1);

    pulse(1, 0, 0);
    repeat (7) pulse(0, 1, 0);
    pulse(1, 0, 0);
    chk("arp_err_7acp", 64'(arp_err_cnt), 64'(m_err));
    repeat (8) pulse(0, 1, 0);
    pulse(1, 1, 0);
    chk("arp_err_8acp", 64'(arp_err_cnt), 64'(m_err));
    pulse(0, 0, 1);
    pulse(1, 0, 1);
    pulse(1, 1, 1);
    chk("arp_err_combo", 64'(arp_err_cnt), 64'(m_err));

    set_ack(0);
    pulse(0, 1, 1);
    trig_coincident(1'b0);
    chk("missed_reload", 64'(missed_cnt), 64'(m_missed));
    chk("req_reload_pending", 64'(sweep_req), 64'd1);
    trig_coincident(1'b1);
    chk("clr_wins_missed", 64'(missed_cnt), 64'd0);
    chk("clr_arp_err", 64'(arp_err_cnt), 64'd0);

    calibrated = 1'b0;
    m_mode = 0;
    step(1);
    chk("drain_running", 64'(running), 64'd0);
    chk("drain_req", 64'(sweep_req), 64'd1);
    set_ack(1);
    step(2);
    chk("drain_done_req", 64'(sweep_req), 64'd0);
    chk("queue_empty_drain", 64'(exp_q.size()), 64'd0);
    calibrated = 1'b1;
    step(3);
    m_mode = 1;
    pulse(0, 0, 1);
    chk("sync_ignores_trig", 64'(running), 64'd0);
    pulse(1, 0, 0);
    chk("rerun_after_arp", 64'(running), 64'd1);

    acp_cnt_v = $urandom_range(4, 12);
    acp_cnt   = 32'(acp_cnt_v);
    for (int i = 0; i < 80; i++) begin
      a = ($urandom_range(0, 9) == 0);
      c = ($urandom_range(0, 2) != 0);
      t = ($urandom_range(0, 3) == 0);
      if (!(a | c | t)) c = 1'b1;
      pulse(a, c, t);
    end
    step(2);
    chk("rand_arp_err", 64'(arp_err_cnt), 64'(m_err));
    chk("rand_missed", 64'(missed_cnt), 64'(m_missed));
    chk("queue_empty_rand", 64'(exp_q.size()), 64'd0);

    clr = 1'b1;
    step(1);
    clr = 1'b0;
    m_missed = 0;
    m_err    = 0;
    set_ack(0);
    repeat (6) pulse(0, 0, 1);
    while (m_err < 5) pulse(1, 0, 0);
    chk("pre_rst_missed", 64'(missed_cnt), 64'd5);
    chk("pre_rst_arp_err", 64'(arp_err_cnt), 64'd5);
    chk("pre_rst_req", 64'(sweep_req), 64'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    exp_q.delete();
    m_mode = 0; m_pending = 0; m_missed = 0; m_err = 0;
    step(2);
    rst_n = 1'b1;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
